// File: rtl/pe_array_out_collector.sv
// PE-array result collector: lossy-input FIFO to valid/ready stream with framing.
// Define COLLECT_STATS_EN to add accepted/dropped beat counters.
module pe_array_out_collector #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int FRAME_LEN  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din_v,
  input  logic [2*DATA_WIDTH-1:0]       din,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [2*DATA_WIDTH-1:0]       m_tdata,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          clr_ovf
`ifdef COLLECT_STATS_EN
  ,
  output logic [31:0]                   rx_cnt,
  output logic [31:0]                   drop_cnt
`endif
);

  localparam int W  = 2 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);
  localparam logic [FW-1:0] FMAX = FW'(FRAME_LEN - 1);

  typedef enum logic {BODY, LAST} frame_e;

  frame_e        fst;
  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] fcnt;
  logic [FW-1:0] fcnt_nx;
  logic [LW-1:0] ram_cnt;
  logic          pop;
  logic          acc;
  logic          drop;
  logic          load;
  logic          ram_rd;
  logic          bypass;
  logic          ram_wr;

  // The output register holds one word; the RAM holds level minus that word.
  always_comb begin
    pop     = m_tvalid & m_tready;
    acc     = din_v & ((level != FULL) | pop);
    drop    = din_v & (level == FULL) & ~pop;
    ram_cnt = level - LW'(m_tvalid);
    load    = ~m_tvalid | pop;
    ram_rd  = load & (ram_cnt != '0);
    bypass  = load & (ram_cnt == '0) & acc;
    ram_wr  = acc & ~bypass;
    fcnt_nx = fcnt;
    if (pop)
      fcnt_nx = (fcnt == FMAX) ? '0 : fcnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ram_wr)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      fst      <= BODY;
      level    <= '0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcnt     <= '0;
    end else begin
      fcnt <= fcnt_nx;
      if (ram_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (ram_rd)
        rd_ptr <= rd_ptr + 1'b1;
      // A newly loaded word's frame position is the post-pop counter value.
      if (load) begin
        m_tvalid <= ram_rd | bypass;
        if (ram_rd)
          m_tdata <= mem[rd_ptr];
        else if (bypass)
          m_tdata <= din;
        fst <= ((ram_rd | bypass) && fcnt_nx == FMAX) ? LAST : BODY;
      end
      if (acc & ~pop)
        level <= level + 1'b1;
      else if (pop & ~acc)
        level <= level - 1'b1;
      if (drop)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  assign m_tlast = (fst == LAST);

`ifdef COLLECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else if (clr_ovf) begin
      rx_cnt   <= '0;
      drop_cnt <= '0;
    end else begin
      if (acc && rx_cnt != '1)
        rx_cnt <= rx_cnt + 1'b1;
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_array_out_collector.sv
// Scoreboard bench for pe_array_out_collector.
// Directed bursts, stalls, overflow, mid-frame reset.
module tb_pe_array_out_collector;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int FL    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        din_v = 1'b0;
  logic [31:0] din = '0;
  logic        m_tready = 1'b0;
  logic        clr_ovf = 1'b0;
  logic        m_tvalid;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic [5:0]  level;
  logic        overflow;
`ifdef COLLECT_STATS_EN
  logic [31:0] rx_cnt;
  logic [31:0] drop_cnt;
`endif

  pe_array_out_collector #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .FRAME_LEN(FL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din_v(din_v),
    .din(din),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata(m_tdata),
    .m_tlast(m_tlast),
    .level(level),
    .overflow(overflow),
    .clr_ovf(clr_ovf)
`ifdef COLLECT_STATS_EN
    ,
    .rx_cnt(rx_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          acc_idx = 0;
  logic [32:0] exp_q[$];
  logic [31:0] hold_d;
  logic        hold_l;
  bit          stalled = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: samples at negedge, pops scoreboard on each handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_data", 64'(m_tdata), 64'(hold_d));
        check("stall_last", 64'(m_tlast), 64'(hold_l));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL extra_beat: got %h expected none", m_tdata);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("beat_data", 64'(m_tdata), 64'(e[31:0]));
          check("beat_last", 64'(m_tlast), 64'(e[32]));
        end
      end
      stalled = m_tvalid && !m_tready;
      hold_d  = m_tdata;
      hold_l  = m_tlast;
    end
  end

  task automatic beat(input logic [31:0] d, input bit acc);
    din_v = 1'b1;
    din   = d;
    if (acc) begin
      exp_q.push_back({(acc_idx % FL) == FL - 1, d});
      acc_idx++;
    end
    @(posedge clk);
    #1;
    din_v = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_tdata"}, 64'(m_tdata), 64'd0);
    check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    check({tag, "_level"}, 64'(level), 64'd0);
    check({tag, "_ovf"}, 64'(overflow), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    din_v    = 1'b0;
    m_tready = 1'b0;
    clr_ovf  = 1'b0;
    rst_n    = 1'b0;
    #2;
    exp_q.delete();
    acc_idx = 0;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    m_tready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++)
      @(posedge clk);
    @(posedge clk);
    #1;
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_empty"}, 64'(m_tvalid), 64'd0);
    check({tag, "_level0"}, 64'(level), 64'd0);
    m_tready = 1'b0;
  endtask

  initial begin
    #1;
    do_reset("rst0");

    // Burst with ready high; first word visible right after its accept edge.
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      beat(32'h0001_0000 + 32'(i), 1'b1);
      if (i == 0) begin
        check("first_valid", 64'(m_tvalid), 64'd1);
        check("first_data", 64'(m_tdata), 64'h0001_0000);
      end
    end
    drain("burst");
    check("burst_ovf", 64'(overflow), 64'd0);

    // Fill to capacity, then one dropped beat.
    m_tready = 1'b0;
    for (int i = 0; i < 32; i++)
      beat(32'h0002_0000 + 32'(i), 1'b1);
    check("fill_level", 64'(level), 64'd32);
    check("fill_ovf", 64'(overflow), 64'd0);
    beat(32'hDEAD_BEEF, 1'b0);
    check("drop_ovf", 64'(overflow), 64'd1);
    check("drop_level", 64'(level), 64'd32);
    drain("fill");
    check("ovf_sticky", 64'(overflow), 64'd1);
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    check("ovf_clr", 64'(overflow), 64'd0);

    // Full with simultaneous write and pop.
    for (int i = 0; i < 32; i++)
      beat(32'h0003_0000 + 32'(i), 1'b1);
    m_tready = 1'b1;
    beat(32'h0003_00AA, 1'b1);
    m_tready = 1'b0;
    check("fullpop_level", 64'(level), 64'd32);
    check("fullpop_ovf", 64'(overflow), 64'd0);
    drain("fullpop");

    // Ready toggling during a continuous 40-beat stream.
    do_reset("rst1");
    for (int i = 0; i < 40; i++) begin
      din_v    = 1'b1;
      din      = 32'h0004_0000 + 32'(i);
      m_tready = (i % 2) == 1;
      exp_q.push_back({(acc_idx % FL) == FL - 1, din});
      acc_idx++;
      @(posedge clk);
      #1;
    end
    din_v = 1'b0;
    drain("toggle");

    // Mid-frame reset after 5 pops with 10 words held.
    do_reset("rst2");
    for (int i = 0; i < 15; i++)
      beat(32'h0005_0000 + 32'(i), 1'b1);
    m_tready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    m_tready = 1'b0;
    check("mid_level", 64'(level), 64'd10);
    do_reset("midrst");
    m_tready = 1'b1;
    for (int i = 0; i < 16; i++)
      beat(32'h0006_0000 + 32'(i), 1'b1);
    drain("postrst");

    // 34 beats into a stalled FIFO: 32 kept, 2 dropped.
    do_reset("rst3");
    for (int i = 0; i < 34; i++)
      beat(32'h0007_0000 + 32'(i), i < 32);
    check("stat_level", 64'(level), 64'd32);
    check("stat_ovf", 64'(overflow), 64'd1);
`ifdef COLLECT_STATS_EN
    check("rx_cnt", 64'(rx_cnt), 64'd32);
    check("drop_cnt", 64'(drop_cnt), 64'd2);
`endif
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    check("stat_ovf_clr", 64'(overflow), 64'd0);
`ifdef COLLECT_STATS_EN
    check("rx_cnt_clr", 64'(rx_cnt), 64'd0);
    check("drop_cnt_clr", 64'(drop_cnt), 64'd0);
`endif
    drain("stat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pe_array_out_collector.md
Name: pe_array_out_collector

Overview:
- Receive end of the PE-array result stream.
- Accepts the array's `dout_v`/`dout` beats, which have no backpressure.
- Buffers them in a FIFO and re-emits them as a valid/ready master stream with `m_tlast` framing every FRAME_LEN beats, toward DMA/host capture.
- Reports words lost to overflow with a sticky flag, so result drops are never silent.

Parameters:
- DATA_WIDTH, 16, width of one real/imag half; the stream word is 2*DATA_WIDTH.
- FIFO_DEPTH, 32, total word capacity including the output register; power of two, ≥ 4.
- FRAME_LEN, 16, beats per output frame; ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din_v  in  1  beat valid from the PE array (`dout_v`); no ready returned.
- din  in  2*DATA_WIDTH  beat data from the PE array (`dout`).
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  2*DATA_WIDTH  output beat data.
- m_tlast  out  1  last beat of frame.
- level  out  $clog2(FIFO_DEPTH)+1  words currently held.
- overflow  out  1  sticky: at least one beat dropped.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset (rst_n=0, async):
  - m_tvalid=0, m_tdata=0, m_tlast=0, level=0, overflow=0.
  - Frame counter=0; FIFO pointers=0.
  - Contents discarded, including mid-frame data; the next frame starts at beat 0.
- Storage:
  - FIFO RAM plus one output register; level counts both.
  - Handshake: pop = m_tvalid & m_tready.
  - Accept: din_v & (level<FIFO_DEPTH | pop).
  - Full with din_v and pop in the same cycle: write accepted, level unchanged.
- Drop: din_v & level==FIFO_DEPTH & !pop.
  - Beat discarded.
  - overflow←1 next edge; stays 1 until clr_ovf=1 or reset.
  - If clr_ovf and a drop occur in the same cycle, set wins.
- Latency: beat accepted at edge N when the FIFO is empty → m_tvalid=1 with that data after edge N (visible in cycle N+1). Zero-bubble throughput: one beat per cycle while m_tready=1.
- Output stability: while m_tvalid & !m_tready, m_tdata and m_tlast hold constant; m_tvalid never drops without pop.
- Ordering: strict FIFO order; no reordering or duplication.
- Frame state machine, two states on the frame counter fcnt (0..FRAME_LEN-1):
  - BODY: m_tlast=0.
  - LAST: when fcnt==FRAME_LEN-1, m_tlast=1.
  - fcnt advances only on pop; wraps to 0 after the LAST pop.
  - FRAME_LEN=1: m_tlast=1 on every beat.
  - Dropped beats do not advance fcnt, so framing counts delivered words only.
- level arithmetic:
  - level+1 on accept without pop; level-1 on pop without accept; unchanged on both or neither.
  - Never exceeds FIFO_DEPTH; never underflows.
  - Pointers wrap modulo FIFO_DEPTH.
- Empty: m_tvalid=0; m_tready is ignored.

Optional Feature:
- Macro: COLLECT_STATS_EN.
- Defined:
  - Adds outputs rx_cnt[31:0] (accepted beats) and drop_cnt[31:0] (dropped beats).
  - Both reset to 0, increment by 1 per event, and saturate at 32'hFFFF_FFFF.
  - Both cleared together with overflow by clr_ovf.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then 16 beats din=32'h0001_0000..32'h0001_000F with m_tready=1 → same 16 words out in order, first m_tvalid one cycle after the first accept; m_tlast=1 only on 32'h0001_000F; overflow=0.
- m_tready=0, push 32 beats → level=32, no drop. Push a 33rd beat (32'hDEAD_BEEF) → dropped, overflow=1, level=32. Then m_tready=1 → exactly 32 words out; the first two frames end with m_tlast at beats 15 and 31.
- Full FIFO, din_v=1 and m_tready=1 in the same cycle → beat accepted, level stays 32, overflow stays 0.
- Toggle m_tready 1/0 every cycle during 40 continuous beats → m_tdata stable across every stalled cycle; all 40 delivered in order; m_tlast on beats 15 and 31.
- Assert rst_n=0 mid-frame after 5 pops with level=10 → all outputs 0 immediately. After release, a new 16-beat burst gives m_tlast on its 16th beat.
- COLLECT_STATS_EN defined, 34 beats pushed into a full-capacity stall → rx_cnt=32, drop_cnt=2. clr_ovf pulse → both 0 and overflow=0.
